i2cs_reg_slave: RTL and testbench



---
 rtl/i2cs_reg_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2cs_reg_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cs_reg_slave.sv
// i2cs_reg_slave: I2C target with a byte-wide register port.
// SCL/SDA are oversampled by clk, glitch-filtered, and decoded into
// START/STOP and bit events. A 7-bit device address is followed by a
// register pointer and write data, or by read data sourced from reg_rdata.
// SDA is driven open-drain via sda_oe. There is no clock stretching.
module i2cs_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         REG_AW   = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  // Bit 0 carries SCL and bit 1 carries SDA in every line vector below.
  logic [1:0]    sync_p0, sync_p1, line_f, line_fd;
  logic [CW-1:0] filt_cnt [2];

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic byte_done, rx_shift;

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              rw, rw_nxt, mack, mack_nxt, re_d;
  logic              sda_oe_nxt, busy_nxt, reg_we_nxt, reg_re_nxt;
  logic [REG_AW-1:0] reg_addr_nxt;
  logic [7:0]        reg_wdata_nxt;

  // Pad synchroniser and glitch filter.
  // A line only changes after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      line_f  <= 2'b11;
      line_fd <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      sync_p0 <= {sda_i, scl_i};
      sync_p1 <= sync_p0;
      line_fd <= line_f;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == line_f[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CW'(FILT_LEN - 1)) begin
          line_f[i]   <= sync_p1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign scl_f     = line_f[0];
  assign sda_f     = line_f[1];
  assign scl_rise  = scl_f & ~line_fd[0];
  assign scl_fall  = ~scl_f & line_fd[0];
  assign start_det = scl_f & line_fd[1] & ~sda_f;
  assign stop_det  = scl_f & ~line_fd[1] & sda_f;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign rx_shift  = scl_rise && (bit_cnt < 4'd8);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode. START and STOP override every state.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = S_DEV_ADDR;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_DEV_ADDR: if (byte_done)
                      state_nxt = (shreg[7:1] == DEV_ADDR) ? S_DEV_ACK : S_WAIT_STOP;
        S_DEV_ACK:  if (scl_fall) state_nxt = rw ? S_RDATA : S_PTR;
        S_PTR:      if (byte_done) state_nxt = S_PTR_ACK;
        S_PTR_ACK:  if (scl_fall) state_nxt = S_WDATA;
        S_WDATA:    if (byte_done) state_nxt = S_WACK;
        S_WACK:     if (scl_fall) state_nxt = S_WDATA;
        S_RDATA:    if (byte_done) state_nxt = S_RACK;
        S_RACK:     if (scl_fall) state_nxt = mack ? S_RDATA : S_WAIT_STOP;
        default:    state_nxt = state;
      endcase
    end
  end

  // Datapath and output decode.
  // SDA only moves on SCL falling; bits are sampled on SCL rising.
  always_comb begin
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    rw_nxt        = rw;
    mack_nxt      = mack;
    sda_oe_nxt    = sda_oe;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    busy_nxt      = busy;
    if (start_det) begin
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else if (stop_det) begin
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      // Read data arrives one clock after the read strobe.
      if (re_d) shreg_nxt = reg_rdata;
      case (state)
        S_DEV_ADDR: begin
          if (rx_shift) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (byte_done && (shreg[7:1] == DEV_ADDR)) begin
            sda_oe_nxt = 1'b1;
            rw_nxt     = shreg[0];
          end
        end
        S_DEV_ACK: begin
          if (scl_rise && rw) reg_re_nxt = 1'b1;
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            sda_oe_nxt  = rw ? ~shreg[7] : 1'b0;
          end
        end
        S_PTR: begin
          if (rx_shift) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (byte_done) begin
            reg_addr_nxt = shreg[REG_AW-1:0];
            sda_oe_nxt   = 1'b1;
          end
        end
        S_PTR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
          end
        end
        S_WDATA: begin
          if (rx_shift) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (byte_done) begin
            reg_wdata_nxt = shreg;
            reg_we_nxt    = 1'b1;
            sda_oe_nxt    = 1'b1;
          end
        end
        S_WACK: begin
          if (scl_fall) begin
            bit_cnt_nxt  = '0;
            sda_oe_nxt   = 1'b0;
            reg_addr_nxt = reg_addr + REG_AW'(1);
          end
        end
        S_RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) bit_cnt_nxt = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
            end else if (bit_cnt != 4'd0) begin
              sda_oe_nxt = ~shreg[6];
              shreg_nxt  = {shreg[6:0], 1'b0};
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            mack_nxt = ~sda_f;
            if (!sda_f) begin
              reg_addr_nxt = reg_addr + REG_AW'(1);
              reg_re_nxt   = 1'b1;
            end
          end
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            sda_oe_nxt  = mack ? ~shreg[7] : 1'b0;
          end
        end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rw        <= 1'b0;
      mack      <= 1'b0;
      re_d      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      rw        <= rw_nxt;
      mack      <= mack_nxt;
      re_d      <= reg_re;
      sda_oe    <= sda_oe_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= reg_re_nxt;
      busy      <= busy_nxt;
    end
  end

  // Byte shifter. This register holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_i2cs_reg_slave.sv
// Bench for i2cs_reg_slave: bit-banged I2C master, register bank model,
// table-driven write vectors, directed read/abort/reset sequences and
// randomized transactions checked against a pointer/memory reference model.
module tb_i2cs_reg_slave;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  logic [7:0]  mem [256];
  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];
  int checks = 0, errors = 0;
  int both_cnt = 0, wide_cnt = 0, oe_cnt = 0, oe_mark;
  logic we_prev = 1'b0, re_prev = 1'b0;
  logic [7:0] model_ptr;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    int         exp_we;
  } wvec_t;
  wvec_t tv [5];

  int         kind, n;
  logic [7:0] p, d, rd, a;
  logic       ack;
  logic [7:0] wd [4];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2cs_reg_slave #(.DEV_ADDR(7'h3C), .REG_AW(8), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register bank: answers reads one clock later and logs every strobe.
  always @(negedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    if ((reg_we && we_prev) || (reg_re && re_prev)) wide_cnt <= wide_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    we_prev <= reg_we;
    re_prev <= reg_re;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] wb, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(wb[i]);
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] rb, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      rb[i] = b;
    end
    send_bit(~give_ack);
  endtask

  initial begin
    tv[0] = '{8'h78, 8'h10, 8'hA5, 8'h5A, 1'b1, 2};
    tv[1] = '{8'h78, 8'hFF, 8'h11, 8'h22, 1'b1, 2};
    tv[2] = '{8'h7A, 8'h10, 8'h33, 8'h44, 1'b0, 0};
    tv[3] = '{8'h78, 8'h7F, 8'h00, 8'hFF, 1'b1, 2};
    tv[4] = '{8'h38, 8'h00, 8'hC3, 8'h3C, 1'b0, 0};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset state
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    model_ptr = 8'h00;

    // One-clock SDA glitch while SCL is high must not look like START
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(3 * Q);
    chk("glitch_busy", busy, 0);

    // Table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      we_q.delete();
      oe_mark = oe_cnt;
      i2c_start();
      chk("start_busy", busy, 1);
      write_byte(tv[v].addr_byte, ack); chk("dev_ack", ack, tv[v].exp_ack);
      write_byte(tv[v].ptr, ack);       chk("ptr_ack", ack, tv[v].exp_ack);
      write_byte(tv[v].d0, ack);        chk("d0_ack", ack, tv[v].exp_ack);
      write_byte(tv[v].d1, ack);        chk("d1_ack", ack, tv[v].exp_ack);
      i2c_stop();
      tick(2 * Q);
      chk("stop_busy", busy, 0);
      chk("we_count", we_q.size(), tv[v].exp_we);
      if (tv[v].exp_ack) begin
        a = tv[v].ptr + 8'd1;
        chk("we0", we_q[0], {tv[v].ptr, tv[v].d0});
        chk("we1", we_q[1], {a, tv[v].d1});
        mem[tv[v].ptr] = tv[v].d0;
        mem[a] = tv[v].d1;
        model_ptr = tv[v].ptr + 8'd2;
      end else begin
        chk("miss_no_oe", oe_cnt - oe_mark, 0);
      end
      chk("addr_after_wr", reg_addr, model_ptr);
    end

    // Pointer write, repeated START, two-byte read with ACK then NACK
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    we_q.delete(); re_q.delete();
    i2c_start();
    write_byte(8'h78, ack); chk("rd_dev_ack", ack, 1);
    write_byte(8'h20, ack); chk("rd_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h79, ack); chk("rd_devr_ack", ack, 1);
    read_byte(rd, 1'b1);    chk("rd_byte0", rd, 8'h3C);
    read_byte(rd, 1'b0);    chk("rd_byte1", rd, 8'hC3);
    i2c_stop();
    tick(2 * Q);
    chk("rd_re_count", re_q.size(), 2);
    chk("rd_re_addr0", re_q[0], 8'h20);
    chk("rd_re_addr1", re_q[1], 8'h21);
    chk("rd_final_addr", reg_addr, 8'h21);
    chk("rd_no_we", we_q.size(), 0);
    chk("rd_busy", busy, 0);

    // STOP after a half byte: pointer kept, no write strobe
    we_q.delete();
    i2c_start();
    write_byte(8'h78, ack); chk("ab_dev_ack", ack, 1);
    write_byte(8'h40, ack); chk("ab_ptr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    tick(2 * Q);
    chk("ab_no_we", we_q.size(), 0);
    chk("ab_busy", busy, 0);
    chk("ab_addr", reg_addr, 8'h40);

    // Reset while the target is driving a zero read bit
    mem[8'h50] = 8'h00;
    i2c_start();
    write_byte(8'h78, ack); chk("rr_dev_ack", ack, 1);
    write_byte(8'h50, ack); chk("rr_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h79, ack); chk("rr_devr_ack", ack, 1);
    recv_bit(ack); recv_bit(ack); recv_bit(ack);
    chk("rr_oe_before", sda_oe, 1);
    we_q.delete(); re_q.delete();
    rst = 1'b1;
    tick(1);
    chk("rr_oe_after", sda_oe, 0);
    chk("rr_busy", busy, 0);
    chk("rr_addr", reg_addr, 0);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    rst = 1'b0;   tick(Q);
    chk("rr_no_strobe", we_q.size() + re_q.size(), 0);
    model_ptr = 8'h00;

    // Randomized writes, pointer reads and current-address reads
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      p    = 8'($urandom);
      we_q.delete(); re_q.delete();
      i2c_start();
      write_byte((kind == 2) ? 8'h79 : 8'h78, ack); chk("rnd_dev_ack", ack, 1);
      if (kind != 2) begin
        write_byte(p, ack); chk("rnd_ptr_ack", ack, 1);
        model_ptr = p;
      end
      if (kind == 0) begin
        for (int k = 0; k < n; k++) begin
          wd[k] = 8'($urandom);
          write_byte(wd[k], ack); chk("rnd_wr_ack", ack, 1);
        end
        i2c_stop();
        tick(2 * Q);
        chk("rnd_we_count", we_q.size(), n);
        for (int k = 0; k < n; k++) begin
          a = model_ptr + 8'(k);
          chk("rnd_we", we_q[k], {a, wd[k]});
          mem[a] = wd[k];
        end
        model_ptr = model_ptr + 8'(n);
      end else begin
        if (kind == 1) begin
          i2c_start();
          write_byte(8'h79, ack); chk("rnd_devr_ack", ack, 1);
        end
        for (int k = 0; k < n; k++) begin
          a = model_ptr + 8'(k);
          read_byte(rd, k != n - 1);
          chk("rnd_rd", rd, mem[a]);
        end
        i2c_stop();
        tick(2 * Q);
        chk("rnd_re_count", re_q.size(), n);
        model_ptr = model_ptr + 8'(n - 1);
      end
      chk("rnd_addr", reg_addr, model_ptr);
      chk("rnd_busy", busy, 0);
    end

    chk("we_re_overlap", both_cnt, 0);
    chk("strobe_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
